pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
// - Multi-cycle fetch/execute controller for the 8-bit microcontroller.
// - Owns the program counter (PC) and drives the shared PC incrementer (in -> in+1, external).
// - Sequences memory fetch, instruction-register load and execute hand-off.
// - Applies jumps and halts.
// - Sits between the instruction memory port, the incrementer and the execute datapath.
// PARAMETERS
// - ADDR_W     8      PC / memory address width; incrementer width matches.
// - RESET_VEC  8'h00  PC value loaded on reset (ADDR_W bits).
// PORTS
// - clk        in   1       Single clock; all state updates on rising edge.
// - rst_n      in   1       Synchronous, active-low reset, sampled on rising edge of clk.
// - run        in   1       Level: 1 = execute program, 0 = stop at next instruction boundary.
// - inc_in     out  ADDR_W  To incrementer input; equals the current PC (combinational).
// - inc_out    in   ADDR_W  From incrementer output (PC+1).
// - mem_req    out  1       Fetch request to instruction memory.
// - mem_addr   out  ADDR_W  Fetch address; equals the PC while mem_req=1.
// - mem_ack    in   1       Memory data valid; qualifies the fetched word.
// - ir_load    out  1       1-cycle pulse: capture the fetched word into the IR.
// - exec_start out  1       1-cycle pulse: execute unit begins the decoded instruction.
// - exec_done  in   1       Execute unit finished; jump_en, jump_addr and halt are valid this cycle.
// - jump_en    in   1       Taken jump/branch; sampled only when exec_done=1.
// - jump_addr  in   ADDR_W  Jump target.
// - halt       in   1       HALT instruction retired; sampled only when exec_done=1.
// - pc         out  ADDR_W  Current PC (registered).
// - state      out  3       FSM state, for debug.
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge), from any state, including mid-fetch or mid-execute:
//   - state=IDLE, pc=RESET_VEC, mem_req=0, ir_load=0, exec_start=0.
//   - Any outstanding request is abandoned; a late mem_ack is ignored.
// - State encoding: IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, HALT=5. Values 6 and 7 go to IDLE.
// - IDLE: run=1 -> FETCH; otherwise stay.
// - FETCH: mem_req=1, mem_addr=pc; next cycle -> WAIT.
// - WAIT:
//   - mem_req stays 1 and mem_addr stays pc until mem_ack.
//   - On mem_ack=1:
//     - pc <= inc_out.
//     - ir_load=1 for exactly the next cycle.
//     - mem_req=0 from the next cycle.
//     - -> DECODE.
//   - Wait is unbounded; there is no timeout.
// - DECODE: one cycle; exec_start=1 for exactly the next cycle; -> EXEC.
// - EXEC: wait for exec_done=1, then:
//   - jump_en=1 -> pc <= jump_addr. The jump overrides the earlier increment.
//   - halt=1 -> HALT.
//   - else run=1 -> FETCH.
//   - else run=0 -> IDLE.
//   - jump_en and halt together: jump applied, then HALT. The PC holds the target.
// - HALT: stay while run=1; run=0 -> IDLE. A new run=1 then resumes from the current pc.
// - run falling mid-instruction: the instruction completes normally; the FSM exits to IDLE at the EXEC boundary.
// - mem_ack outside WAIT and exec_done outside EXEC: ignored, with no state or pc change.
// - Arithmetic: the PC wraps modulo 2^ADDR_W. At pc=8'hFF, inc_out=8'h00 is loaded with no flag.
// - Minimum instruction time: 4 cycles (FETCH, WAIT with immediate ack, DECODE, EXEC with immediate done).
// - All outputs are registered except inc_in, which is a direct copy of pc.
// TESTING
// - Reset with run=1 held:
//   - cycle 1: FETCH, mem_req=1, mem_addr=00.
//   - ack -> pc=01 and an ir_load pulse.
// - Straight-line code, ack and done immediate:
//   - pc goes 00,01,02,... with one new instruction every 4 cycles.
//   - ir_load and exec_start are each high for exactly 1 cycle per instruction.
// - Wrap-around: start at pc=FF and fetch -> pc=00. The next mem_addr is 00.
// - Jump: exec_done=1, jump_en=1, jump_addr=8'h3C -> next FETCH has mem_addr=3C.
// - Halt plus jump in the same cycle (jump_addr=8'h10):
//   - state=HALT, pc=10.
//   - run 1->0->1 -> resumes fetch at 10.
// - Reset mid-WAIT with delayed ack:
//   - state=IDLE, pc=RESET_VEC, mem_req=0.
//   - A stale mem_ack one cycle later does not change pc.

Source files
------------

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle fetch/execute controller for the 8-bit microcontroller. It owns
// the program counter, drives the shared external incrementer and sequences
// fetch -> wait-for-memory -> decode -> execute, applying jumps and halts.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         synchronous active-low reset
//   run_i          level: 1 = run program, 0 = stop at next instruction boundary
//   inc_in_o       to incrementer input (direct copy of pc)
//   inc_out_i      from incrementer output (pc + 1)
//   mem_req_o      instruction fetch request
//   mem_addr_o     fetch address (equals pc while mem_req_o = 1)
//   mem_ack_i      fetched word valid (only honoured in WAIT)
//   ir_load_o      1-cycle pulse: capture fetched word into the IR
//   exec_start_o   1-cycle pulse: execute unit starts the decoded instruction
//   exec_done_i    execute unit finished (only honoured in EXEC)
//   jump_en_i      taken jump, qualified by exec_done_i
//   jump_addr_i    jump target
//   halt_i         HALT retired, qualified by exec_done_i
//   pc_o           current program counter (registered)
//   state_o        FSM state for debug
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,
  output logic [ADDR_W-1:0] inc_in_o,
  input  logic [ADDR_W-1:0] inc_out_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  output logic              ir_load_o,
  output logic              exec_start_o,
  input  logic              exec_done_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_req_q;
  logic              ir_load_q;
  logic              exec_start_q;

  // Next-state and next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (run_i) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Unbounded wait for memory; the increment is taken only with the data.
        if (mem_ack_i) begin
          state_d = ST_DECODE;
          pc_d    = inc_out_i;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done_i) begin
          // A jump overrides the increment already applied in WAIT; it is
          // applied even when the same instruction also halts.
          if (jump_en_i) begin
            pc_d = jump_addr_i;
          end else begin
            pc_d = pc_q;
          end
          if (halt_i) begin
            state_d = ST_HALT;
          end else if (run_i) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_HALT: begin
        if (run_i) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, PC and registered outputs; outputs are derived from the next state
  // so they are valid in the same cycle the FSM enters the matching state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_VEC;
      mem_addr_q   <= RESET_VEC;
      mem_req_q    <= 1'b0;
      ir_load_q    <= 1'b0;
      exec_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_addr_q   <= pc_d;
      mem_req_q    <= (state_d == ST_FETCH) || (state_d == ST_WAIT);
      ir_load_q    <= (state_q == ST_WAIT) && mem_ack_i;
      exec_start_q <= (state_q == ST_DECODE);
    end
  end

  assign inc_in_o     = pc_q;
  assign pc_o         = pc_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_req_o    = mem_req_q;
  assign ir_load_o    = ir_load_q;
  assign exec_start_o = exec_start_q;
  assign state_o      = state_q;

endmodule
